// File: rtl/util_timestamp_insert_if.sv
// Stream bundle shared by the sample input and the framed output of util_timestamp_insert.
// Carries valid/ready/data plus the transfer-active qualifier (xfer_req).
// master drives valid/data/xfer_req and samples ready; slave is the mirror image.
interface util_timestamp_insert_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  valid;
    logic                  ready;
    logic                  xfer_req;
    logic [DATA_WIDTH-1:0] data;

    modport master (output valid, output data, output xfer_req, input ready);
    modport slave  (input valid, input data, input xfer_req, output ready);
endinterface

// File: rtl/util_timestamp_insert.sv
// Purpose: frames a plain sample-block stream as one timestamp word followed by timestamp_every blocks.
// Latency: blocks pass through combinationally (0 cycles); the timestamp word comes from a register.
// Backpressure: m_axis.ready goes straight back to s_axis.ready for blocks; input is held off while a timestamp word is offered.
//
// Ports:
//   dma_clk, reset      clock and asynchronous active-high reset
//   start_timestamp     first frame timestamp, captured on the xfer_req rising edge
//   timestamp_every     blocks per frame, captured on the xfer_req rising edge (0 = plain passthrough)
//   s_axis (slave)      sample blocks in, plus xfer_req
//   m_axis (master)     timestamp words and sample blocks out; xfer_req mirrors s_axis
//   frame_count         timestamp words accepted downstream since the last xfer_req rise (saturating)
module util_timestamp_insert #(
    parameter int DATA_WIDTH          = 64,
    parameter int SAMPLES_PER_CHANNEL = 1,
    parameter int TS_WIDTH            = 64
) (
    input  logic                          dma_clk,
    input  logic                          reset,
    input  logic [63:0]                   start_timestamp,
    input  logic [31:0]                   timestamp_every,
    util_timestamp_insert_if.slave        s_axis,
    util_timestamp_insert_if.master       m_axis,
    output logic [31:0]                   frame_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_TS   = 2'd2,
        ST_DATA = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  xfer_q, xfer_d;
    logic [31:0]           every_q, every_d;
    logic [TS_WIDTH-1:0]   step_q, step_d;
    logic [TS_WIDTH-1:0]   ts_next_q, ts_next_d;
    logic [31:0]           blk_cnt_q, blk_cnt_d;
    logic [31:0]           frame_count_q, frame_count_d;

    logic                  xfer_rise;
    logic [63:0]           step_full;
    logic                  m_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] m_data;

    always_comb begin
        state_d       = state_q;
        xfer_d        = s_axis.xfer_req;
        every_d       = every_q;
        step_d        = step_q;
        ts_next_d     = ts_next_q;
        blk_cnt_d     = blk_cnt_q;
        frame_count_d = frame_count_q;
        m_valid       = 1'b0;
        s_ready       = 1'b0;
        m_data        = '0;

        xfer_rise = s_axis.xfer_req && !xfer_q;
        // Frame step is fixed for the whole transfer, so it is multiplied once at capture.
        step_full = 64'(timestamp_every) * 64'(SAMPLES_PER_CHANNEL);

        case (state_q)
            ST_IDLE: begin
                if (xfer_rise) begin
                    every_d       = timestamp_every;
                    step_d        = step_full[TS_WIDTH-1:0];
                    ts_next_d     = start_timestamp[TS_WIDTH-1:0];
                    blk_cnt_d     = '0;
                    frame_count_d = '0;
                    state_d       = (timestamp_every == 32'd0) ? ST_PASS : ST_TS;
                end
            end
            ST_PASS: begin
                m_valid = s_axis.valid;
                s_ready = m_axis.ready;
                m_data  = s_axis.data;
            end
            ST_TS: begin
                m_valid = 1'b1;
                m_data  = DATA_WIDTH'(ts_next_q);
                if (m_axis.ready) begin
                    ts_next_d     = ts_next_q + step_q;
                    blk_cnt_d     = '0;
                    frame_count_d = (frame_count_q != '1) ? frame_count_q + 32'd1 : frame_count_q;
                    state_d       = ST_DATA;
                end
            end
            ST_DATA: begin
                m_valid = s_axis.valid;
                s_ready = m_axis.ready;
                m_data  = s_axis.data;
                if (s_axis.valid && m_axis.ready) begin
                    if (blk_cnt_q == every_q - 32'd1) begin
                        state_d = ST_TS;
                    end else begin
                        blk_cnt_d = blk_cnt_q + 32'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Losing xfer_req abandons whatever frame is in flight; downstream resets on it too.
        if (state_q != ST_IDLE && !s_axis.xfer_req) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge dma_clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            xfer_q        <= 1'b0;
            every_q       <= '0;
            step_q        <= '0;
            ts_next_q     <= '0;
            blk_cnt_q     <= '0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            xfer_q        <= xfer_d;
            every_q       <= every_d;
            step_q        <= step_d;
            ts_next_q     <= ts_next_d;
            blk_cnt_q     <= blk_cnt_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign m_axis.valid    = m_valid;
    assign m_axis.data     = m_data;
    assign m_axis.xfer_req = s_axis.xfer_req;
    assign s_axis.ready    = s_ready;
    assign frame_count     = frame_count_q;

endmodule
